umul_bi_array: RTL and testbench

Multi-channel unary stochastic multiplier with a run-window controller and per-channel ones-counters. Each of CHANNELS lanes multiplies an incoming unary bitstream iA[i] by a stored binary weight. The weight is converted on the fly by two input-gated sobolrng instances per lane. Lanes operate in unipolar or bipolar coding, selected per run. A shared FSM runs one full Sobol period (2^BITWIDTH cycles), counts product ones per lane, and presents binary results with a done pulse. The block sits between stream generators and the binary back-end of the unary datapath.

---
 rtl/umul_bi_array.sv | 143 ++++++++++++++
 tb/tb_umul_bi_array.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/umul_bi_array.sv
// umul_bi_array: multi-lane unary stochastic multiplier with Sobol weight streams and a one-period run window.
// Define UMUL_ACC_EN to build the per-lane ones-counters; without it oAcc is tied to zero.
`default_nettype none

module sobolrng #(
  parameter int BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  output logic [BITWIDTH-1:0] seq
);
  logic [BITWIDTH-1:0] idx;
  logic [BITWIDTH-1:0] onehot;
  logic [BITWIDTH-1:0] vec;

  // First Sobol dimension: XOR in the direction vector picked by the lowest zero bit of the index.
  assign onehot = ~idx & (idx + 1'b1);
  assign vec    = {<<{onehot}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      seq <= '0;
    end else if (clr) begin
      idx <= '0;
      seq <= '0;
    end else if (en) begin
      idx <= idx + 1'b1;
      seq <= seq ^ vec;
    end
  end
endmodule

module umul_bi_array #(
  parameter int BITWIDTH = 8,
  parameter int CHANNELS = 4
) (
  input  logic                             iClk,
  input  logic                             iRstN,
  input  logic [CHANNELS-1:0]              iA,
  input  logic [CHANNELS*BITWIDTH-1:0]     iB,
  input  logic                             iLoadB,
  input  logic                             iMode,
  input  logic                             iStart,
  output logic                             oBusy,
  output logic                             oDone,
  output logic [CHANNELS-1:0]              oMult,
  output logic [CHANNELS*(BITWIDTH+1)-1:0] oAcc
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [BITWIDTH-1:0] cnt;
  logic                mode_r;
  logic                run;
  logic                clr;
  logic                load_ok;

  assign run     = (state == RUN);
  assign clr     = (state == IDLE) & iStart;
  assign load_ok = iLoadB & ((state == IDLE) | (state == DONE));
  assign oBusy   = run | (state == DONE);
  assign oDone   = (state == DONE);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            state  <= RUN;
            cnt    <= '0;
            mode_r <= iMode;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == {BITWIDTH{1'b1}}) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [BITWIDTH-1:0] b_r;
    logic [BITWIDTH-1:0] seq_top;
    logic [BITWIDTH-1:0] seq_bot;
    logic                gt_top;
    logic                gt_bot;

    always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN)       b_r <= '0;
      else if (load_ok) b_r <= iB[i*BITWIDTH +: BITWIDTH];
    end

    // Each RNG only steps on the input value it serves, so each sees its own full sequence.
    sobolrng #(.BITWIDTH(BITWIDTH)) u_top (
      .clk   (iClk),
      .rst_n (iRstN),
      .en    (~iA[i] & run),
      .clr   (clr),
      .seq   (seq_top)
    );

    sobolrng #(.BITWIDTH(BITWIDTH)) u_bot (
      .clk   (iClk),
      .rst_n (iRstN),
      .en    (iA[i] & run),
      .clr   (clr),
      .seq   (seq_bot)
    );

    assign gt_top   = (b_r > seq_top);
    assign gt_bot   = (b_r > seq_bot);
    assign oMult[i] = mode_r ? ((iA[i] & gt_bot) | (~iA[i] & ~gt_top))
                             : (iA[i] & gt_bot);

`ifdef UMUL_ACC_EN
    logic [BITWIDTH:0] acc;

    always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN)   acc <= '0;
      else if (clr) acc <= '0;
      else if (run) acc <= acc + {{BITWIDTH{1'b0}}, oMult[i]};
    end

    assign oAcc[i*(BITWIDTH+1) +: BITWIDTH+1] = acc;
`else
    assign oAcc[i*(BITWIDTH+1) +: BITWIDTH+1] = '0;
`endif
  end
endmodule

`default_nettype wire

// File: tb/tb_umul_bi_array.sv
// Directed testbench for umul_bi_array (BITWIDTH=8, CHANNELS=4); expected oAcc follows UMUL_ACC_EN.
`default_nettype none

module tb_umul_bi_array;
  localparam int BW = 8;
  localparam int CH = 4;
  localparam int AW = CH * (BW + 1);
`ifdef UMUL_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic          iClk   = 1'b0;
  logic          iRstN  = 1'b0;
  logic [CH-1:0] iA     = '0;
  logic [CH*BW-1:0] iB  = '0;
  logic          iLoadB = 1'b0;
  logic          iMode  = 1'b0;
  logic          iStart = 1'b0;
  wire           oBusy;
  wire           oDone;
  wire  [CH-1:0] oMult;
  wire  [AW-1:0] oAcc;

  int n_checks = 0;
  int n_fail   = 0;
  int tally[CH];
  int done_at, done_cnt, busy_bad;
  logic [AW-1:0] acc_done, acc_hold;

  always #5 iClk = ~iClk;

  umul_bi_array #(.BITWIDTH(BW), .CHANNELS(CH)) dut (
    .iClk(iClk), .iRstN(iRstN), .iA(iA), .iB(iB), .iLoadB(iLoadB), .iMode(iMode),
    .iStart(iStart), .oBusy(oBusy), .oDone(oDone), .oMult(oMult), .oAcc(oAcc)
  );

  function automatic logic [AW-1:0] exp_acc(input int a3, input int a2, input int a1, input int a0);
    return ACC_ON ? {9'(a3), 9'(a2), 9'(a1), 9'(a0)} : '0;
  endfunction

  function automatic logic [CH*BW-1:0] wts(input int b3, input int b2, input int b1, input int b0);
    return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  task automatic load_weights(input logic [CH*BW-1:0] b);
    iB = b; iLoadB = 1'b1;
    @(posedge iClk); #1;
    iLoadB = 1'b0;
  endtask

  // One accepted start plus 259 cycles; k counts edges after the start edge E0.
  task automatic run_window(input int load_at, input logic [CH*BW-1:0] new_b, input int pulse_at);
    logic m;
    for (int i = 0; i < CH; i++) tally[i] = 0;
    done_at = -1; done_cnt = 0; busy_bad = 0;
    m = iMode;
    if (load_at < 0) begin iB = new_b; iLoadB = 1'b1; end
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0; iLoadB = 1'b0;
    iMode = ~m;
    for (int k = 0; k <= 258; k++) begin
      if (oBusy !== (k <= 256)) busy_bad++;
      if (oDone === 1'b1) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (k <= 255) for (int i = 0; i < CH; i++) tally[i] += int'(oMult[i]);
      if (k == 256) acc_done = oAcc;
      if (k == load_at) begin iB = new_b; iLoadB = 1'b1; end
      if (k == pulse_at) iStart = 1'b1;
      @(posedge iClk); #1;
      iLoadB = 1'b0; iStart = 1'b0;
    end
    acc_hold = oAcc;
    iMode = m;
  endtask

  task automatic test_reset;
    iRstN = 1'b0; iA = 4'b1111;
    repeat (2) @(posedge iClk); #1;
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
    n_checks++; if (oDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", oDone); end
    n_checks++; if (oAcc !== '0) begin n_fail++; $display("FAIL reset_acc: got %h expected 0", oAcc); end
    n_checks++; if (oMult !== 4'b0000) begin n_fail++; $display("FAIL reset_mult_a1: got %b expected 0000", oMult); end
    iA = 4'b0101; #1;
    n_checks++; if (oMult !== 4'b0000) begin n_fail++; $display("FAIL reset_mult_a0: got %b expected 0000", oMult); end
    iRstN = 1'b1;
    repeat (3) @(posedge iClk); #1;
    n_checks++; if (oBusy !== 1'b0 || oDone !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b done %b expected 0 0", oBusy, oDone); end
  endtask

  task automatic test_unipolar;
    int e[CH];
    iMode = 1'b0; iA = 4'b1111;
    load_weights(wts(255, 128, 64, 0));
    run_window(1000, '0, 1000);
    e = '{0, 64, 128, 255};
    n_checks++; if (done_at != 256 || done_cnt != 1) begin n_fail++; $display("FAIL uni_done: at %0d count %0d expected at 256 count 1", done_at, done_cnt); end
    n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL uni_busy: %0d bad cycles expected 0", busy_bad); end
    n_checks++; if (acc_done !== exp_acc(255, 128, 64, 0)) begin n_fail++; $display("FAIL uni_acc: got %h expected %h", acc_done, exp_acc(255, 128, 64, 0)); end
    n_checks++; if (acc_hold !== exp_acc(255, 128, 64, 0)) begin n_fail++; $display("FAIL uni_acc_hold: got %h expected %h", acc_hold, exp_acc(255, 128, 64, 0)); end
    for (int i = 0; i < CH; i++) begin
      n_checks++; if (tally[i] != e[i]) begin n_fail++; $display("FAIL uni_mult_lane%0d: got %0d ones expected %0d", i, tally[i], e[i]); end
    end
    // zero input stream multiplies every weight to zero
    iA = 4'b0000;
    run_window(1000, '0, 1000);
    n_checks++; if (acc_done !== '0) begin n_fail++; $display("FAIL uni_zero_acc: got %h expected 0", acc_done); end
    iA = 4'b1010;
    load_weights(wts(255, 255, 255, 255));
    run_window(1000, '0, 1000);
    n_checks++; if (acc_done !== exp_acc(255, 0, 255, 0)) begin n_fail++; $display("FAIL uni_mixed_acc: got %h expected %h", acc_done, exp_acc(255, 0, 255, 0)); end
    n_checks++; if (tally[3] != 255 || tally[0] != 0) begin n_fail++; $display("FAIL uni_mixed_mult: lane3 %0d lane0 %0d expected 255 0", tally[3], tally[0]); end
  endtask

  task automatic test_bipolar;
    iMode = 1'b1; iA = 4'b0000;
    load_weights(wts(0, 0, 0, 0));
    run_window(1000, '0, 1000);
    n_checks++; if (acc_done !== exp_acc(256, 256, 256, 256)) begin n_fail++; $display("FAIL bi_neg_acc: got %h expected %h", acc_done, exp_acc(256, 256, 256, 256)); end
    n_checks++; if (tally[2] != 256) begin n_fail++; $display("FAIL bi_neg_mult: got %0d ones expected 256", tally[2]); end
    iA = 4'b1111;
    load_weights(wts(255, 255, 255, 255));
    run_window(1000, '0, 1000);
    n_checks++; if (acc_done !== exp_acc(255, 255, 255, 255)) begin n_fail++; $display("FAIL bi_pos_acc: got %h expected %h", acc_done, exp_acc(255, 255, 255, 255)); end
    iA = 4'b0101;
    load_weights(wts(128, 128, 128, 128));
    run_window(1000, '0, 1000);
    n_checks++; if (acc_done !== exp_acc(128, 128, 128, 128)) begin n_fail++; $display("FAIL bi_half_acc: got %h expected %h", acc_done, exp_acc(128, 128, 128, 128)); end
    n_checks++; if (tally[0] != 128 || tally[1] != 128) begin n_fail++; $display("FAIL bi_half_mult: lane0 %0d lane1 %0d expected 128 128", tally[0], tally[1]); end
    iMode = 1'b0;
  endtask

  task automatic test_load_in_run;
    iMode = 1'b0; iA = 4'b1111;
    load_weights(wts(255, 128, 64, 0));
    run_window(100, wts(40, 30, 20, 10), 1000);
    n_checks++; if (acc_done !== exp_acc(255, 128, 64, 0)) begin n_fail++; $display("FAIL load_run_ignored: got %h expected %h", acc_done, exp_acc(255, 128, 64, 0)); end
  endtask

  task automatic test_load_in_done;
    run_window(256, wts(40, 30, 20, 10), 1000);
    n_checks++; if (acc_done !== exp_acc(255, 128, 64, 0)) begin n_fail++; $display("FAIL load_done_cur: got %h expected %h", acc_done, exp_acc(255, 128, 64, 0)); end
    run_window(1000, '0, 1000);
    n_checks++; if (acc_done !== exp_acc(40, 30, 20, 10)) begin n_fail++; $display("FAIL load_done_next: got %h expected %h", acc_done, exp_acc(40, 30, 20, 10)); end
    n_checks++; if (tally[3] != 40 || tally[0] != 10) begin n_fail++; $display("FAIL load_done_mult: lane3 %0d lane0 %0d expected 40 10", tally[3], tally[0]); end
  endtask

  task automatic test_load_with_start;
    run_window(-1, wts(7, 100, 200, 3), 1000);
    n_checks++; if (acc_done !== exp_acc(7, 100, 200, 3)) begin n_fail++; $display("FAIL load_with_start: got %h expected %h", acc_done, exp_acc(7, 100, 200, 3)); end
  endtask

  task automatic test_start_ignored;
    load_weights(wts(255, 128, 64, 0));
    run_window(1000, '0, 128);
    n_checks++; if (done_cnt != 1 || done_at != 256) begin n_fail++; $display("FAIL start_in_run: done count %0d at %0d expected 1 at 256", done_cnt, done_at); end
    n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL start_in_run_busy: %0d bad cycles expected 0", busy_bad); end
  endtask

  task automatic test_back_to_back;
    int d[$];
    int w;
    iStart = 1'b1;
    @(posedge iClk); #1;
    for (int k = 0; k < 600; k++) begin
      if (oDone === 1'b1) d.push_back(k);
      @(posedge iClk); #1;
    end
    iStart = 1'b0;
    w = 0;
    while (oBusy === 1'b1 && w < 400) begin @(posedge iClk); #1; w++; end
    n_checks++; if (d.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d pulses expected 2", d.size()); end
    else begin
      n_checks++; if (d[0] != 256 || d[1] != 514) begin n_fail++; $display("FAIL b2b_spacing: at %0d and %0d expected 256 and 514", d[0], d[1]); end
    end
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: busy %b expected 0", oBusy); end
    n_checks++; if (oAcc !== exp_acc(255, 128, 64, 0)) begin n_fail++; $display("FAIL b2b_acc: got %h expected %h", oAcc, exp_acc(255, 128, 64, 0)); end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (50) @(posedge iClk);
    #1;
    iRstN = 1'b0;
    #1;
    n_checks++; if (oBusy !== 1'b0 || oDone !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctrl: busy %b done %b expected 0 0", oBusy, oDone); end
    n_checks++; if (oAcc !== '0) begin n_fail++; $display("FAIL mid_reset_acc: got %h expected 0", oAcc); end
    n_checks++; if (oMult !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_mult: got %b expected 0000", oMult); end
    seen = 0;
    repeat (3) begin @(posedge iClk); #1; if (oDone === 1'b1) seen++; end
    iRstN = 1'b1;
    repeat (300) begin @(posedge iClk); #1; if (oDone === 1'b1) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_reset_nodone: got %0d pulses expected 0", seen); end
    load_weights(wts(255, 128, 64, 0));
    run_window(1000, '0, 1000);
    n_checks++; if (acc_done !== exp_acc(255, 128, 64, 0) || done_at != 256) begin n_fail++; $display("FAIL mid_reset_rerun: acc %h at %0d expected %h at 256", acc_done, done_at, exp_acc(255, 128, 64, 0)); end
  endtask

  initial begin
    test_reset();
    test_unipolar();
    test_bipolar();
    test_load_in_run();
    test_load_in_done();
    test_load_with_start();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
